// File: rtl/ccip_tx_almfull_buffer.sv
// CCI-P Tx buffer: absorbs c0/c1 requests in per-channel FIFOs while the FIU's delayed almost-full is high.
// Optional stall counters are built when CCIP_TX_BUF_STATS_EN is defined.

package ccip_tx_buf_pkg;
    localparam int C0_HDR_W    = 74;
    localparam int C1_HDR_W    = 80;
    localparam int CL_DATA_W   = 512;
    localparam int C2_HDR_W    = 9;
    localparam int MMIO_DATA_W = 64;

    typedef struct packed {
        logic [C0_HDR_W-1:0] hdr;
        logic                valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [C1_HDR_W-1:0]  hdr;
        logic [CL_DATA_W-1:0] data;
        logic                 valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [C2_HDR_W-1:0]    hdr;
        logic [MMIO_DATA_W-1:0] data;
        logic                   valid;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;
endpackage

module ccip_tx_almfull_chan #(
    parameter int DEPTH         = 16,
    parameter int ALMFULL_SLACK = 8,
    parameter int WIDTH         = 74
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             fiu_almfull,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             afu_almfull,
    output logic             overflow,
    output logic [31:0]      stall_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALMFULL_CNT = CNT_W'(DEPTH - ALMFULL_SLACK);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;
    logic [WIDTH-1:0] head;

    // An empty FIFO forwards the incoming request straight to the output
    // register, giving one cycle of latency; a pop frees a slot for a push at full.
    // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        empty      = (count == '0);
        full       = (count == FULL_CNT);
        pop        = !fiu_almfull && (!empty || push);
        accept     = push && (!full || pop);
        head       = empty ? push_data : mem[rd_ptr];
        count_next = count + CNT_W'(accept) - CNT_W'(pop);
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            afu_almfull <= 1'b1;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_data <= head;
            end
            count       <= count_next;
            out_valid   <= pop;
            afu_almfull <= (count_next >= ALMFULL_CNT);
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef CCIP_TX_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!empty && fiu_almfull && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
`endif
endmodule

module ccip_tx_almfull_buffer
    import ccip_tx_buf_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset,
    input  t_if_ccip_Tx afu_sTx,
    output logic        afu_c0TxAlmFull,
    output logic        afu_c1TxAlmFull,
    output t_if_ccip_Tx fiu_sTx,
    input  logic        fiu_c0TxAlmFull,
    input  logic        fiu_c1TxAlmFull,
    output logic [1:0]  err_overflow,
    output logic [31:0] stat_c0_stall,
    output logic [31:0] stat_c1_stall
);
    localparam int C1_W = C1_HDR_W + CL_DATA_W;

    logic                c0_valid;
    logic [C0_HDR_W-1:0] c0_hdr;
    logic                c0_ovf;
    logic                c1_valid;
    logic [C1_W-1:0]     c1_bits;
    logic                c1_ovf;
    t_if_ccip_c2_Tx      c2_q;

    ccip_tx_almfull_chan #(
        .DEPTH(DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK), .WIDTH(C0_HDR_W)
    ) c0_chan (
        .clk(pClk),
        .reset(pck_cp2af_softReset),
        .push(afu_sTx.c0.valid),
        .push_data(afu_sTx.c0.hdr),
        .fiu_almfull(fiu_c0TxAlmFull),
        .out_valid(c0_valid),
        .out_data(c0_hdr),
        .afu_almfull(afu_c0TxAlmFull),
        .overflow(c0_ovf),
        .stall_count(stat_c0_stall)
    );

    ccip_tx_almfull_chan #(
        .DEPTH(DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK), .WIDTH(C1_W)
    ) c1_chan (
        .clk(pClk),
        .reset(pck_cp2af_softReset),
        .push(afu_sTx.c1.valid),
        .push_data({afu_sTx.c1.hdr, afu_sTx.c1.data}),
        .fiu_almfull(fiu_c1TxAlmFull),
        .out_valid(c1_valid),
        .out_data(c1_bits),
        .afu_almfull(afu_c1TxAlmFull),
        .overflow(c1_ovf),
        .stall_count(stat_c1_stall)
    );

    // MMIO responses are never throttled by almost-full.
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            c2_q <= '0;
        end else begin
            c2_q <= afu_sTx.c2;
        end
    end

    assign err_overflow = {c1_ovf, c0_ovf};

    always_comb begin
        fiu_sTx          = '0;
        fiu_sTx.c0.valid = c0_valid;
        fiu_sTx.c0.hdr   = c0_hdr;
        fiu_sTx.c1.valid = c1_valid;
        fiu_sTx.c1.hdr   = c1_bits[C1_W-1:CL_DATA_W];
        fiu_sTx.c1.data  = c1_bits[CL_DATA_W-1:0];
        fiu_sTx.c2       = c2_q;
    end
endmodule

// File: tb/tb_ccip_tx_almfull_buffer.sv
// Self-checking bench for ccip_tx_almfull_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_ccip_tx_almfull_buffer;
    import ccip_tx_buf_pkg::*;

    localparam int DEPTH      = 16;
    localparam int SLACK      = 8;
    localparam int ALMFULL_AT = DEPTH - SLACK;
    localparam int C1_W       = C1_HDR_W + CL_DATA_W;
`ifdef CCIP_TX_BUF_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        pClk = 1'b0;
    logic        reset;
    t_if_ccip_Tx afu_stx;
    t_if_ccip_Tx fiu_stx;
    logic        fiu_af0;
    logic        fiu_af1;
    logic        afu_af0;
    logic        afu_af1;
    logic [1:0]  err_ovf;
    logic [31:0] st0;
    logic [31:0] st1;

    int n_checks = 0;
    int n_pass   = 0;

    ccip_tx_almfull_buffer #(.DEPTH(DEPTH), .ALMFULL_SLACK(SLACK)) dut (
        .pClk(pClk),
        .pck_cp2af_softReset(reset),
        .afu_sTx(afu_stx),
        .afu_c0TxAlmFull(afu_af0),
        .afu_c1TxAlmFull(afu_af1),
        .fiu_sTx(fiu_stx),
        .fiu_c0TxAlmFull(fiu_af0),
        .fiu_c1TxAlmFull(fiu_af1),
        .err_overflow(err_ovf),
        .stat_c0_stall(st0),
        .stat_c1_stall(st1)
    );

    always #5 pClk = ~pClk;

    // Reference model: each channel is an ordered queue of accepted requests.
    logic [C0_HDR_W-1:0] q0 [$];
    logic [C1_W-1:0]     q1 [$];
    logic                exp_c0_valid;
    logic [C0_HDR_W-1:0] exp_c0_hdr;
    logic                exp_c1_valid;
    logic [C1_W-1:0]     exp_c1_bits;
    t_if_ccip_c2_Tx      exp_c2;
    logic                exp_af0;
    logic                exp_af1;
    logic [1:0]          exp_ovf;
    logic [31:0]         exp_st0;
    logic [31:0]         exp_st1;

    function automatic logic [607:0] rnd_bits();
        logic [607:0] r;
        for (int i = 0; i < 19; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Advance the model by the current inputs, then clock the DUT; outputs are sampled 1 ns after the edge.
    task automatic tick();
        if (reset) begin
            q0.delete();
            q1.delete();
            exp_c0_valid = 1'b0;
            exp_c1_valid = 1'b0;
            exp_c2       = '0;
            exp_af0      = 1'b1;
            exp_af1      = 1'b1;
            exp_ovf      = 2'b00;
            exp_st0      = '0;
            exp_st1      = '0;
        end else begin
            if (STATS_ON && q0.size() != 0 && fiu_af0 && exp_st0 != 32'hFFFF_FFFF) exp_st0 = exp_st0 + 32'd1;
            if (STATS_ON && q1.size() != 0 && fiu_af1 && exp_st1 != 32'hFFFF_FFFF) exp_st1 = exp_st1 + 32'd1;
            if (afu_stx.c0.valid) begin
                if (q0.size() < DEPTH || !fiu_af0) q0.push_back(afu_stx.c0.hdr);
                else exp_ovf[0] = 1'b1;
            end
            if (afu_stx.c1.valid) begin
                if (q1.size() < DEPTH || !fiu_af1) q1.push_back({afu_stx.c1.hdr, afu_stx.c1.data});
                else exp_ovf[1] = 1'b1;
            end
            exp_c0_valid = !fiu_af0 && q0.size() != 0;
            if (exp_c0_valid) exp_c0_hdr = q0.pop_front();
            exp_c1_valid = !fiu_af1 && q1.size() != 0;
            if (exp_c1_valid) exp_c1_bits = q1.pop_front();
            exp_af0 = (q0.size() >= ALMFULL_AT);
            exp_af1 = (q1.size() >= ALMFULL_AT);
            exp_c2  = afu_stx.c2;
        end
        @(posedge pClk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        afu_stx = '0;
        fiu_af0 = 1'b0;
        fiu_af1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_c1(output logic [C1_W-1:0] bits);
        logic [607:0] r;
        r    = rnd_bits();
        bits = r[C1_W-1:0];
        {afu_stx.c1.hdr, afu_stx.c1.data} = bits;
        afu_stx.c1.valid = 1'b1;
    endtask

    task automatic test_reset();
        logic [607:0] r;
        reset   = 1'b1;
        fiu_af0 = 1'b0;
        fiu_af1 = 1'b0;
        r       = rnd_bits();
        afu_stx = r[$bits(t_if_ccip_Tx)-1:0];
        afu_stx.c0.valid = 1'b1;
        afu_stx.c1.valid = 1'b1;
        afu_stx.c2.valid = 1'b1;
        tick();
        tick();
        n_checks++; if (fiu_stx.c0.valid !== 1'b0) $display("FAIL reset_c0_valid got=%b exp=0", fiu_stx.c0.valid); else n_pass++;
        n_checks++; if (fiu_stx.c1.valid !== 1'b0) $display("FAIL reset_c1_valid got=%b exp=0", fiu_stx.c1.valid); else n_pass++;
        n_checks++; if (fiu_stx.c2.valid !== 1'b0) $display("FAIL reset_c2_valid got=%b exp=0", fiu_stx.c2.valid); else n_pass++;
        n_checks++; if ({afu_af1, afu_af0} !== 2'b11) $display("FAIL reset_afu_almfull got=%b exp=11", {afu_af1, afu_af0}); else n_pass++;
        n_checks++; if (err_ovf !== 2'b00) $display("FAIL reset_overflow got=%b exp=00", err_ovf); else n_pass++;
        n_checks++; if ({st1, st0} !== 64'd0) $display("FAIL reset_stats got=%h exp=0", {st1, st0}); else n_pass++;
        reset   = 1'b0;
        afu_stx = '0;
        tick();
        n_checks++; if ({afu_af1, afu_af0} !== 2'b00) $display("FAIL reset_release_almfull got=%b exp=00", {afu_af1, afu_af0}); else n_pass++;
    endtask

    task automatic test_single_c0();
        logic [607:0]        r;
        logic [C0_HDR_W-1:0] h;
        do_reset();
        repeat (10) tick();
        n_checks++; if (fiu_stx.c0.valid !== 1'b0) $display("FAIL single_idle_valid got=%b exp=0", fiu_stx.c0.valid); else n_pass++;
        r = rnd_bits();
        h = r[C0_HDR_W-1:0];
        afu_stx.c0.hdr   = h;
        afu_stx.c0.valid = 1'b1;
        tick();
        afu_stx.c0.valid = 1'b0;
        n_checks++; if (fiu_stx.c0.valid !== 1'b1) $display("FAIL single_latency_valid got=%b exp=1", fiu_stx.c0.valid); else n_pass++;
        n_checks++; if (fiu_stx.c0.hdr !== h) $display("FAIL single_hdr got=%h exp=%h", fiu_stx.c0.hdr, h); else n_pass++;
        n_checks++; if (afu_af0 !== 1'b0) $display("FAIL single_almfull got=%b exp=0", afu_af0); else n_pass++;
        tick();
        n_checks++; if (fiu_stx.c0.valid !== 1'b0) $display("FAIL single_after_valid got=%b exp=0", fiu_stx.c0.valid); else n_pass++;
        n_checks++; if (afu_af0 !== 1'b0) $display("FAIL single_after_almfull got=%b exp=0", afu_af0); else n_pass++;
    endtask

    task automatic test_c1_backpressure();
        logic [C1_W-1:0] sent [8];
        do_reset();
        fiu_af1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_c1(sent[i]);
            tick();
            n_checks++; if (fiu_stx.c1.valid !== 1'b0) $display("FAIL bp_held_valid[%0d] got=%b exp=0", i, fiu_stx.c1.valid); else n_pass++;
            n_checks++; if (afu_af1 !== (i + 1 >= ALMFULL_AT)) $display("FAIL bp_almfull[%0d] got=%b exp=%b", i, afu_af1, (i + 1 >= ALMFULL_AT)); else n_pass++;
        end
        afu_stx.c1.valid = 1'b0;
        repeat (2) tick();
        n_checks++; if (fiu_stx.c1.valid !== 1'b0) $display("FAIL bp_hold_valid got=%b exp=0", fiu_stx.c1.valid); else n_pass++;
        fiu_af1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (fiu_stx.c1.valid !== 1'b1) $display("FAIL bp_drain_valid[%0d] got=%b exp=1", i, fiu_stx.c1.valid); else n_pass++;
            n_checks++; if ({fiu_stx.c1.hdr, fiu_stx.c1.data} !== sent[i]) $display("FAIL bp_drain_data[%0d] got=%h exp=%h", i, {fiu_stx.c1.hdr, fiu_stx.c1.data}, sent[i]); else n_pass++;
            n_checks++; if (afu_af1 !== (7 - i >= ALMFULL_AT)) $display("FAIL bp_drain_almfull[%0d] got=%b exp=%b", i, afu_af1, (7 - i >= ALMFULL_AT)); else n_pass++;
        end
        tick();
        n_checks++; if (fiu_stx.c1.valid !== 1'b0) $display("FAIL bp_empty_valid got=%b exp=0", fiu_stx.c1.valid); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [607:0]        r;
        logic [C0_HDR_W-1:0] sent [17];
        int                  n;
        do_reset();
        fiu_af0 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            r = rnd_bits();
            sent[i] = r[C0_HDR_W-1:0];
            afu_stx.c0.hdr   = sent[i];
            afu_stx.c0.valid = 1'b1;
            tick();
            n_checks++; if (err_ovf !== ((i == 16) ? 2'b01 : 2'b00)) $display("FAIL ovf_push[%0d] got=%b exp=%b", i, err_ovf, ((i == 16) ? 2'b01 : 2'b00)); else n_pass++;
        end
        afu_stx.c0.valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (err_ovf !== 2'b01) $display("FAIL ovf_sticky got=%b exp=01", err_ovf); else n_pass++;
        n_checks++; if (afu_af0 !== 1'b1) $display("FAIL ovf_almfull got=%b exp=1", afu_af0); else n_pass++;
        fiu_af0 = 1'b0;
        n = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (fiu_stx.c0.valid === 1'b1) begin
                if (n < 16) begin
                    n_checks++; if (fiu_stx.c0.hdr !== sent[n]) $display("FAIL ovf_drain_hdr[%0d] got=%h exp=%h", n, fiu_stx.c0.hdr, sent[n]); else n_pass++;
                end
                n++;
            end
        end
        n_checks++; if (n !== 16) $display("FAIL ovf_issue_count got=%0d exp=16", n); else n_pass++;
        n_checks++; if (err_ovf !== 2'b01) $display("FAIL ovf_sticky_after_drain got=%b exp=01", err_ovf); else n_pass++;
    endtask

    task automatic test_c2_passthrough();
        logic [607:0]   r;
        t_if_ccip_c2_Tx sent;
        do_reset();
        fiu_af0 = 1'b1;
        fiu_af1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r = rnd_bits();
            sent       = r[$bits(t_if_ccip_c2_Tx)-1:0];
            sent.valid = 1'b1;
            afu_stx.c2 = sent;
            tick();
            n_checks++; if (fiu_stx.c2 !== sent) $display("FAIL c2_pass[%0d] got=%h exp=%h", i, fiu_stx.c2, sent); else n_pass++;
        end
        afu_stx.c2 = '0;
        tick();
        n_checks++; if (fiu_stx.c2.valid !== 1'b0) $display("FAIL c2_idle_valid got=%b exp=0", fiu_stx.c2.valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [C1_W-1:0] bits;
        do_reset();
        fiu_af1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_c1(bits);
            tick();
        end
        afu_stx.c1.valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({fiu_stx.c1.valid, fiu_stx.c0.valid} !== 2'b00) $display("FAIL midrst_valid got=%b exp=00", {fiu_stx.c1.valid, fiu_stx.c0.valid}); else n_pass++;
        n_checks++; if ({afu_af1, afu_af0} !== 2'b11) $display("FAIL midrst_almfull got=%b exp=11", {afu_af1, afu_af0}); else n_pass++;
        tick();
        n_checks++; if ({afu_af1, afu_af0} !== 2'b00) $display("FAIL midrst_release_almfull got=%b exp=00", {afu_af1, afu_af0}); else n_pass++;
        fiu_af1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (fiu_stx.c1.valid !== 1'b0) $display("FAIL midrst_no_issue[%0d] got=%b exp=0", i, fiu_stx.c1.valid); else n_pass++;
        end
    endtask

    task automatic test_stats();
        logic [607:0] r;
        do_reset();
        fiu_af0 = 1'b1;
        r = rnd_bits();
        afu_stx.c0.hdr   = r[C0_HDR_W-1:0];
        afu_stx.c0.valid = 1'b1;
        tick();
        afu_stx.c0.valid = 1'b0;
        repeat (20) tick();
        n_checks++; if (st0 !== (STATS_ON ? 32'd20 : 32'd0)) $display("FAIL stats_c0 got=%0d exp=%0d", st0, (STATS_ON ? 20 : 0)); else n_pass++;
        n_checks++; if (st1 !== 32'd0) $display("FAIL stats_c1 got=%0d exp=0", st1); else n_pass++;
        fiu_af0 = 1'b0;
        tick();
        n_checks++; if (fiu_stx.c0.valid !== 1'b1) $display("FAIL stats_release_valid got=%b exp=1", fiu_stx.c0.valid); else n_pass++;
        tick();
        n_checks++; if (st0 !== (STATS_ON ? 32'd20 : 32'd0)) $display("FAIL stats_c0_frozen got=%0d exp=%0d", st0, (STATS_ON ? 20 : 0)); else n_pass++;
    endtask

    task automatic test_random();
        logic [607:0] r;
        int           phase;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            phase = (i / 250) % 4;
            r = rnd_bits();
            afu_stx = r[$bits(t_if_ccip_Tx)-1:0];
            afu_stx.c0.valid = ($urandom_range(99) < ((phase == 1) ? 90 : 50));
            afu_stx.c1.valid = ($urandom_range(99) < ((phase == 3) ? 90 : 45));
            afu_stx.c2.valid = ($urandom_range(99) < 30);
            fiu_af0 = ($urandom_range(99) < ((phase == 1) ? 85 : (phase == 2) ? 10 : 40));
            fiu_af1 = ($urandom_range(99) < ((phase == 3) ? 85 : (phase == 2) ? 10 : 40));
            reset   = ($urandom_range(999) == 0);
            tick();
            n_checks++; if (fiu_stx.c0.valid !== exp_c0_valid) $display("FAIL rnd_c0_valid@%0d got=%b exp=%b", i, fiu_stx.c0.valid, exp_c0_valid); else n_pass++;
            if (exp_c0_valid) begin
                n_checks++; if (fiu_stx.c0.hdr !== exp_c0_hdr) $display("FAIL rnd_c0_hdr@%0d got=%h exp=%h", i, fiu_stx.c0.hdr, exp_c0_hdr); else n_pass++;
            end
            n_checks++; if (fiu_stx.c1.valid !== exp_c1_valid) $display("FAIL rnd_c1_valid@%0d got=%b exp=%b", i, fiu_stx.c1.valid, exp_c1_valid); else n_pass++;
            if (exp_c1_valid) begin
                n_checks++; if ({fiu_stx.c1.hdr, fiu_stx.c1.data} !== exp_c1_bits) $display("FAIL rnd_c1_data@%0d got=%h exp=%h", i, {fiu_stx.c1.hdr, fiu_stx.c1.data}, exp_c1_bits); else n_pass++;
            end
            n_checks++; if (fiu_stx.c2.valid !== exp_c2.valid) $display("FAIL rnd_c2_valid@%0d got=%b exp=%b", i, fiu_stx.c2.valid, exp_c2.valid); else n_pass++;
            if (exp_c2.valid) begin
                n_checks++; if (fiu_stx.c2 !== exp_c2) $display("FAIL rnd_c2@%0d got=%h exp=%h", i, fiu_stx.c2, exp_c2); else n_pass++;
            end
            n_checks++; if ({afu_af1, afu_af0} !== {exp_af1, exp_af0}) $display("FAIL rnd_almfull@%0d got=%b exp=%b", i, {afu_af1, afu_af0}, {exp_af1, exp_af0}); else n_pass++;
            n_checks++; if (err_ovf !== exp_ovf) $display("FAIL rnd_overflow@%0d got=%b exp=%b", i, err_ovf, exp_ovf); else n_pass++;
            n_checks++; if ({st1, st0} !== {exp_st1, exp_st0}) $display("FAIL rnd_stats@%0d got=%h exp=%h", i, {st1, st0}, {exp_st1, exp_st0}); else n_pass++;
        end
        reset   = 1'b0;
        afu_stx = '0;
    endtask

    initial begin
        reset   = 1'b1;
        afu_stx = '0;
        fiu_af0 = 1'b0;
        fiu_af1 = 1'b0;
        test_reset();
        test_single_c0();
        test_c1_backpressure();
        test_overflow();
        test_c2_passthrough();
        test_reset_mid();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ccip_tx_almfull_buffer.md
Name: ccip_tx_almfull_buffer

Overview:
- CCI-P Tx request buffer placed between the AFU and registered CCI-P pipeline stages.
- Pipelining the interface delays the FIU's c0/c1 TxAlmFull by N cycles, so an AFU can overrun the FIU.
- This block absorbs in-flight c0/c1 requests in per-channel FIFOs and only issues them to the FIU while the FIU's almost-full is low.
- It regenerates its own almost-full toward the AFU with configurable slack. c2 (MMIO response) is registered through unbuffered.

Parameters:
- DEPTH, 16, entries per channel FIFO (power of 2, >=4).
- ALMFULL_SLACK, 8, free entries reserved after afu almost-full asserts (must be <DEPTH, >=8 per CCI-P post-almfull allowance).

Ports:
- pClk  input  1  CCI-P primary clock.
- pck_cp2af_softReset  input  1  synchronous active-high reset.
- afu_sTx  input  t_if_ccip_Tx  Tx requests from AFU (c0, c1, c2).
- afu_c0TxAlmFull  output  1  c0 almost-full to AFU.
- afu_c1TxAlmFull  output  1  c1 almost-full to AFU.
- fiu_sTx  output  t_if_ccip_Tx  Tx requests toward FIU/pipeline.
- fiu_c0TxAlmFull  input  1  c0 almost-full from FIU side.
- fiu_c1TxAlmFull  input  1  c1 almost-full from FIU side.
- err_overflow  output  2  sticky overflow, bit0=c0, bit1=c1.
- stat_c0_stall  output  32  c0 stall-cycle count (optional feature).
- stat_c1_stall  output  32  c1 stall-cycle count (optional feature).

Behaviour:
- One clock pClk; reset pck_cp2af_softReset is synchronous, active-high.
- Reset values:
  - fiu_sTx c0/c1/c2 valid = 0.
  - afu_c0TxAlmFull = afu_c1TxAlmFull = 1.
  - err_overflow = 0.
  - FIFO counts and pointers = 0.
  - stat counters = 0.
- Reset mid-operation discards all queued entries; no partial issue.
- Push: afu_sTx.cN.valid writes hdr (c1: hdr+data) into FIFO N in the same cycle.
- Pop: when FIFO N is non-empty and fiu_cNTxAlmFull is 0, the head is popped and driven onto registered fiu_sTx.cN with valid=1 on the next cycle.
  - One pop per channel per cycle.
  - Otherwise fiu_sTx.cN.valid = 0 next cycle.
- Latency: an empty FIFO with FIU almfull low gives exactly 1 cycle from afu valid to fiu valid (fall-through to the output register).
- Ordering: strict FIFO order within a channel; no cross-channel ordering guaranteed.
- Count N updates as +push -pop, both allowed in the same cycle.
- AFU almost-full: afu_cNTxAlmFull is registered. It is 1 in the cycle after countN (post-update) >= DEPTH-ALMFULL_SLACK, and 0 after it drops below.
- Overflow: a push when countN==DEPTH with no pop in the same cycle drops the request and sets err_overflow[N] (sticky until reset).
  - A push at full with a simultaneous pop is accepted; count stays DEPTH.
- FIU almfull toggling: sampled each cycle. Issue stops the cycle it is sampled 1 and resumes the cycle it is sampled 0. No request is ever lost or duplicated.
- Pointers wrap modulo DEPTH.
- c2: fiu_sTx.c2 <= afu_sTx.c2 every cycle, 1-cycle latency, independent of any almfull.
- All fields other than valid are don't-care when valid=0, but are driven from the FIFO head (no X).

Optional Feature:
- Macro CCIP_TX_BUF_STATS_EN.
- Defined: stat_cN_stall increments each cycle FIFO N is non-empty and fiu_cNTxAlmFull=1. Saturates at 32'hFFFFFFFF; cleared by reset.
- Undefined: stat_c0_stall and stat_c1_stall are tied to 0 and no counter logic is built.

Test Plan:
- Single c0 read, FIU almfull 0: afu c0 valid at cycle 10 -> fiu c0 valid at cycle 11 with identical hdr. afu_c0TxAlmFull stays 0.
- fiu_c1TxAlmFull=1, 8 c1 writes pushed back-to-back:
  - No fiu c1 valid while almfull is held.
  - afu_c1TxAlmFull rises the cycle after the 8th push (count=8).
  - Release almfull -> 8 writes issue on 8 consecutive cycles in push order with matching data; almfull out returns to 0 once count<8.
- Hold fiu_c0TxAlmFull=1 and push 17 c0 reads -> 16 stored, err_overflow=2'b01 sticky; after release, exactly 16 issue.
- MMIO response on c2 while both FIU almfulls are 1 -> fiu c2 valid 1 cycle later with identical hdr/data.
- 5 c1 entries queued, assert reset 1 cycle:
  - The next cycle shows fiu valid 0 and afu almfulls 1.
  - After reset, almfulls return to 0 and releasing FIU almfull issues nothing.
- With CCIP_TX_BUF_STATS_EN: 1 c0 entry queued, FIU c0 almfull held 20 cycles -> stat_c0_stall=20, stat_c1_stall=0.
